// File: rtl/accel_job_sched.sv
// Job scheduler for the FIR/matrix-multiply accelerator: queues host jobs, issues mode-start
// pulses, watches stream handshakes for completion/length/stall, and posts one completion record per job.
module accel_job_sched #(
    parameter int QDEPTH   = 4,
    parameter int NUM_TAPS = 11,
    parameter int TIMEOUT  = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_mode,
    input  logic [15:0]              cmd_len,
    input  logic [3:0]               cmd_tag,
    output logic                     tap_mode,
    output logic                     fir_mode,
    output logic                     mm_mode,
    output logic                     acc_flush,
    input  logic                     ss_fire,
    input  logic                     sm_fire,
    input  logic                     sm_last,
    output logic                     done_valid,
    input  logic                     done_ready,
    output logic [3:0]               done_tag,
    output logic [1:0]               done_status,
    output logic [15:0]              done_beats,
    output logic                     irq,
    output logic                     busy,
    output logic [$clog2(QDEPTH):0]  q_count
);

    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] MODE_ILL = 2'b00;
    localparam logic [1:0] MODE_TAP = 2'b01;
    localparam logic [1:0] MODE_FIR = 2'b10;
    localparam logic [1:0] MODE_MM  = 2'b11;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_LEN = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;
    localparam logic [1:0] ST_ILL = 2'b11;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, REPORT} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Job FIFO storage; contents are only meaningful between the pointers, so no reset.
    logic [1:0]    q_mode [QDEPTH];
    logic [15:0]   q_len  [QDEPTH];
    logic [3:0]    q_tag  [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    state_t        state;
    logic [1:0]    job_mode;
    logic [15:0]   job_len;
    logic [3:0]    job_tag;
    logic [1:0]    res_status;
    logic [15:0]   beat_cnt;
    logic [15:0]   next_beats;
    logic [WW-1:0] wdog;
    logic [1:0]    head_mode;
    logic          push;
    logic          pop;

    assign cmd_ready  = (count != CW'(QDEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state == IDLE) && (count != '0) && !done_valid;
    assign head_mode  = q_mode[rd_ptr];
    assign next_beats = sat_inc(beat_cnt);
    assign q_count    = count;
    assign irq        = done_valid;
    assign busy       = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            q_mode[wr_ptr] <= cmd_mode;
            q_len[wr_ptr]  <= cmd_len;
            q_tag[wr_ptr]  <= cmd_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Job registers carry data only; they are always written before use.
    always_ff @(posedge clk) begin
        if (pop) begin
            job_mode <= head_mode;
            job_len  <= q_len[rd_ptr];
            job_tag  <= q_tag[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            tap_mode    <= 1'b0;
            fir_mode    <= 1'b0;
            mm_mode     <= 1'b0;
            acc_flush   <= 1'b0;
            beat_cnt    <= '0;
            wdog        <= '0;
            res_status  <= ST_OK;
            done_valid  <= 1'b0;
            done_tag    <= '0;
            done_status <= '0;
            done_beats  <= '0;
        end else begin
            tap_mode  <= 1'b0;
            fir_mode  <= 1'b0;
            mm_mode   <= 1'b0;
            acc_flush <= 1'b0;
            if (done_valid && done_ready) done_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (pop) begin
                        if (head_mode == MODE_ILL) begin
                            res_status <= ST_ILL;
                            beat_cnt   <= '0;
                            state      <= REPORT;
                        end else begin
                            tap_mode <= (head_mode == MODE_TAP);
                            fir_mode <= (head_mode == MODE_FIR);
                            mm_mode  <= (head_mode == MODE_MM);
                            state    <= LAUNCH;
                        end
                    end
                end
                LAUNCH: begin
                    beat_cnt <= '0;
                    wdog     <= '0;
                    state    <= RUN;
                end
                RUN: begin
                    if (job_mode == MODE_TAP) begin
                        if (ss_fire) begin
                            beat_cnt <= next_beats;
                            if (next_beats == 16'(NUM_TAPS)) begin
                                res_status <= ST_OK;
                                state      <= REPORT;
                            end
                        end
                    end else if (sm_fire) begin
                        beat_cnt <= next_beats;
                        // The closing beat is counted before comparing against the requested length.
                        if (sm_last) begin
                            res_status <= (next_beats == job_len) ? ST_OK : ST_LEN;
                            state      <= REPORT;
                        end
                    end

                    if (ss_fire || sm_fire) begin
                        wdog <= '0;
                    end else if (wdog == WW'(TIMEOUT - 1)) begin
                        acc_flush  <= 1'b1;
                        res_status <= ST_TMO;
                        state      <= REPORT;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                REPORT: begin
                    done_valid  <= 1'b1;
                    done_tag    <= job_tag;
                    done_status <= res_status;
                    done_beats  <= beat_cnt;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_job_sched.sv
// Directed bench for accel_job_sched: table of single-job vectors plus hand sequences for
// timeout, queue backpressure, illegal mode and mid-job reset.
module tb_accel_job_sched;
    localparam int QDEPTH   = 4;
    localparam int NUM_TAPS = 11;
    localparam int TIMEOUT  = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mode = '0;
    logic [15:0] cmd_len = '0;
    logic [3:0]  cmd_tag = '0;
    logic        tap_mode, fir_mode, mm_mode, acc_flush;
    logic        ss_fire = 1'b0;
    logic        sm_fire = 1'b0;
    logic        sm_last = 1'b0;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [3:0]  done_tag;
    logic [1:0]  done_status;
    logic [15:0] done_beats;
    logic        irq, busy;
    logic [2:0]  q_count;

    always #5 clk = ~clk;

    accel_job_sched #(.QDEPTH(QDEPTH), .NUM_TAPS(NUM_TAPS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
        .cmd_len(cmd_len), .cmd_tag(cmd_tag),
        .tap_mode(tap_mode), .fir_mode(fir_mode), .mm_mode(mm_mode), .acc_flush(acc_flush),
        .ss_fire(ss_fire), .sm_fire(sm_fire), .sm_last(sm_last),
        .done_valid(done_valid), .done_ready(done_ready), .done_tag(done_tag),
        .done_status(done_status), .done_beats(done_beats),
        .irq(irq), .busy(busy), .q_count(q_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc = 0;
    int tap_cnt = 0, fir_cnt = 0, mm_cnt = 0, flush_cnt = 0;
    int fir_cyc = 0, flush_cyc = 0;
    bit multi_hot = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tap_mode) tap_cnt++;
        if (mm_mode) mm_cnt++;
        if (fir_mode) begin fir_cnt++; fir_cyc = cyc; end
        if (acc_flush) begin flush_cnt++; flush_cyc = cyc; end
        if ((int'(tap_mode) + int'(fir_mode) + int'(mm_mode) + int'(acc_flush)) > 1) multi_hot = 1'b1;
    end

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] len;
        logic [3:0]  tag;
        int          beats;
        logic [1:0]  exp_status;
        logic [15:0] exp_beats;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] m, input logic [15:0] l, input logic [3:0] t);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_len   = l;
        cmd_tag   = t;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
    endtask

    task automatic beat(input bit use_ss, input bit last);
        if (use_ss) ss_fire = 1'b1;
        else begin
            sm_fire = 1'b1;
            sm_last = last;
        end
        tick();
        ss_fire = 1'b0;
        sm_fire = 1'b0;
        sm_last = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !done_valid; i++) tick();
    endtask

    task automatic wait_fir(input int bound);
        for (int i = 0; i < bound && !fir_mode; i++) tick();
    endtask

    task automatic run_job(input int idx, input vec_t v);
        int t0, f0, m0, fl0;
        logic [2:0] exp_pulse;
        t0 = tap_cnt; f0 = fir_cnt; m0 = mm_cnt; fl0 = flush_cnt;
        exp_pulse = (v.mode == 2'b01) ? 3'b100 : (v.mode == 2'b10) ? 3'b010 : 3'b001;
        push(v.mode, v.len, v.tag);
        check($sformatf("v%0d_no_early_pulse", idx), {tap_mode, fir_mode, mm_mode}, 3'b000);
        tick();
        check($sformatf("v%0d_pulse", idx), {tap_mode, fir_mode, mm_mode}, exp_pulse);
        tick();
        for (int i = 1; i <= v.beats; i++) beat(v.mode == 2'b01, i == v.beats);
        check($sformatf("v%0d_valid_m1", idx), done_valid, 1'b0);
        tick();
        check($sformatf("v%0d_valid_m2", idx), done_valid, 1'b1);
        check($sformatf("v%0d_tag", idx), done_tag, v.tag);
        check($sformatf("v%0d_status", idx), done_status, v.exp_status);
        check($sformatf("v%0d_beats", idx), done_beats, v.exp_beats);
        check($sformatf("v%0d_irq", idx), irq, 1'b1);
        check($sformatf("v%0d_busy", idx), busy, 1'b0);
        check($sformatf("v%0d_pulse_count", idx), (tap_cnt - t0) + (fir_cnt - f0) + (mm_cnt - m0), 1);
        check($sformatf("v%0d_no_flush", idx), flush_cnt - fl0, 0);
        consume();
        check($sformatf("v%0d_consumed", idx), done_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected finish before 1 ms");
        $fatal(1);
    end

    initial begin
        int f0, fl0, t0, m0;
        vecs[0] = '{mode: 2'b10, len: 16'd8, tag: 4'd3,  beats: 8,  exp_status: 2'b00, exp_beats: 16'd8};
        vecs[1] = '{mode: 2'b01, len: 16'd0, tag: 4'd1,  beats: 11, exp_status: 2'b00, exp_beats: 16'd11};
        vecs[2] = '{mode: 2'b11, len: 16'd4, tag: 4'd5,  beats: 3,  exp_status: 2'b01, exp_beats: 16'd3};
        vecs[3] = '{mode: 2'b10, len: 16'd5, tag: 4'd9,  beats: 7,  exp_status: 2'b01, exp_beats: 16'd7};
        vecs[4] = '{mode: 2'b11, len: 16'd2, tag: 4'hF, beats: 2,  exp_status: 2'b00, exp_beats: 16'd2};

        rst = 1'b1;
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_pulses", {tap_mode, fir_mode, mm_mode, acc_flush}, 4'b0000);
        check("rst_done", {done_valid, irq, busy}, 3'b000);
        check("rst_fields", {done_tag, done_status, done_beats}, 22'd0);
        check("rst_q_count", q_count, 3'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_job(i, vecs[i]);

        // Stall: no handshakes after the FIR launch.
        f0 = fir_cnt; fl0 = flush_cnt;
        push(2'b10, 16'd4, 4'd2);
        tick();
        wait_done(TIMEOUT + 20);
        check("tmo_done", done_valid, 1'b1);
        check("tmo_status", done_status, 2'b10);
        check("tmo_beats", done_beats, 16'd0);
        check("tmo_tag", done_tag, 4'd2);
        check("tmo_flush_count", flush_cnt - fl0, 1);
        check("tmo_fir_count", fir_cnt - f0, 1);
        check("tmo_flush_delay", flush_cyc - fir_cyc, TIMEOUT + 1);
        consume();

        // Backpressure: five pushes with the host not consuming completions.
        f0 = fir_cnt;
        cmd_valid = 1'b1;
        cmd_mode  = 2'b10;
        cmd_len   = 16'd1;
        for (int j = 0; j < 5; j++) begin
            cmd_tag = 4'(j);
            check($sformatf("bp_ready_%0d", j), cmd_ready, 1'b1);
            tick();
        end
        cmd_valid = 1'b0;
        check("bp_q_full", q_count, 3'd4);
        check("bp_ready_low", cmd_ready, 1'b0);
        check("bp_one_launch", fir_cnt - f0, 1);
        beat(1'b0, 1'b1);
        wait_done(10);
        check("bp_first_tag", done_tag, 4'd0);
        repeat (10) tick();
        check("bp_held_valid", done_valid, 1'b1);
        check("bp_held_launch", fir_cnt - f0, 1);
        check("bp_held_q", q_count, 3'd4);
        consume();
        for (int j = 1; j < 5; j++) begin
            wait_fir(10);
            check($sformatf("bp_launch_%0d", j), fir_mode, 1'b1);
            tick();
            beat(1'b0, 1'b1);
            wait_done(10);
            check($sformatf("bp_tag_%0d", j), done_tag, 4'(j));
            check($sformatf("bp_status_%0d", j), done_status, 2'b00);
            consume();
        end
        check("bp_drained", q_count, 3'd0);

        // Illegal head followed by a normal FIR job.
        t0 = tap_cnt; f0 = fir_cnt; m0 = mm_cnt; fl0 = flush_cnt;
        push(2'b00, 16'd9, 4'd7);
        push(2'b10, 16'd2, 4'd4);
        wait_done(10);
        check("ill_tag", done_tag, 4'd7);
        check("ill_status", done_status, 2'b11);
        check("ill_beats", done_beats, 16'd0);
        check("ill_no_pulse", (tap_cnt - t0) + (fir_cnt - f0) + (mm_cnt - m0) + (flush_cnt - fl0), 0);
        consume();
        wait_fir(10);
        check("ill_next_launch", fir_mode, 1'b1);
        tick();
        beat(1'b0, 1'b0);
        beat(1'b0, 1'b1);
        wait_done(10);
        check("ill_next_tag", done_tag, 4'd4);
        check("ill_next_status", done_status, 2'b00);
        check("ill_next_beats", done_beats, 16'd2);
        consume();

        // Reset while a job runs and another waits in the queue.
        push(2'b10, 16'd8, 4'd6);
        wait_fir(10);
        tick();
        beat(1'b0, 1'b0);
        push(2'b11, 16'd3, 4'd8);
        beat(1'b0, 1'b0);
        check("mid_busy", busy, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        f0 = fir_cnt; m0 = mm_cnt;
        check("mid_rst_q", q_count, 3'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_ready", cmd_ready, 1'b1);
        repeat (8) tick();
        check("mid_rst_no_done", done_valid, 1'b0);
        check("mid_rst_no_launch", (fir_cnt - f0) + (mm_cnt - m0), 0);

        check("pulses_exclusive", multi_hot, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
